data_memory: RTL and testbench

- Word-addressed data memory for the CPU datapath.
- One block-wide write port and three independent read ports.
- Each read port returns a single word and a BLOCK_SIZE-word block starting at its pointer.
- Reads are combinational; writes are synchronous to clk.

---
 rtl/data_memory_if.sv | 29 ++
 rtl/data_memory.sv | 47 ++++
 tb/tb_data_memory.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Bus bundle for data_memory: one block-wide write port and three read ports.
// The master drives pointers and write data; the slave (the memory) returns read data.
interface data_memory_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4
);
  logic [WORD_SIZE-1:0]            ptr_in;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] in_block;
  logic                            write_enable;
  logic [WORD_SIZE-1:0]            ptr_out1;
  logic [WORD_SIZE-1:0]            ptr_out2;
  logic [WORD_SIZE-1:0]            ptr_out3;
  logic [WORD_SIZE-1:0]            out_data1;
  logic [WORD_SIZE-1:0]            out_data2;
  logic [WORD_SIZE-1:0]            out_data3;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] out_block1;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] out_block2;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] out_block3;

  modport master (
    output ptr_in, in_block, write_enable, ptr_out1, ptr_out2, ptr_out3,
    input  out_data1, out_data2, out_data3, out_block1, out_block2, out_block3
  );

  modport slave (
    input  ptr_in, in_block, write_enable, ptr_out1, ptr_out2, ptr_out3,
    output out_data1, out_data2, out_data3, out_block1, out_block2, out_block3
  );
endinterface

// File: rtl/data_memory.sv
// Flop-based word memory: synchronous block write, three combinational read ports.
// Reset loads word i with value i so every location is defined after reset.
module data_memory #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int MEM_DEPTH  = 64
) (
  input logic           clk,
  input logic           rst_n,
  data_memory_if.slave  bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

  // Pointer bits above the memory depth are ignored by design.
  logic unused_ptr_bits;
  assign unused_ptr_bits = ^{bus.ptr_in[WORD_SIZE-1:AW], bus.ptr_out1[WORD_SIZE-1:AW],
                             bus.ptr_out2[WORD_SIZE-1:AW], bus.ptr_out3[WORD_SIZE-1:AW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[AW'(i)] <= WORD_SIZE'(i);
      end
    end else if (bus.write_enable) begin
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        mem[AW'(bus.ptr_in[AW-1:0] + AW'(k))] <= bus.in_block[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Address sums are truncated to AW bits, which gives the modulo-depth wrap.
  always_comb begin
    bus.out_data1  = mem[bus.ptr_out1[AW-1:0]];
    bus.out_data2  = mem[bus.ptr_out2[AW-1:0]];
    bus.out_data3  = mem[bus.ptr_out3[AW-1:0]];
    bus.out_block1 = '0;
    bus.out_block2 = '0;
    bus.out_block3 = '0;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      bus.out_block1[k*WORD_SIZE +: WORD_SIZE] = mem[AW'(bus.ptr_out1[AW-1:0] + AW'(k))];
      bus.out_block2[k*WORD_SIZE +: WORD_SIZE] = mem[AW'(bus.ptr_out2[AW-1:0] + AW'(k))];
      bus.out_block3[k*WORD_SIZE +: WORD_SIZE] = mem[AW'(bus.ptr_out3[AW-1:0] + AW'(k))];
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected reads are queued from a reference
// array when pointers are driven, then popped and compared against the outputs.
module tb_data_memory;
  localparam int W  = 32;
  localparam int B  = 4;
  localparam int D  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          port;
    int          lane;   // -1 selects out_dataN
    logic [W-1:0] exp;
  } sb_t;

  sb_t          sb_q[$];
  logic [W-1:0] model [D];

  data_memory_if #(.WORD_SIZE(W), .BLOCK_SIZE(B)) bus ();

  data_memory #(.WORD_SIZE(W), .BLOCK_SIZE(B), .MEM_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_val(input int port, input int lane);
    logic [W*B-1:0] blk;
    logic [W-1:0]   dat;
    case (port)
      1: begin blk = bus.out_block1; dat = bus.out_data1; end
      2: begin blk = bus.out_block2; dat = bus.out_data2; end
      default: begin blk = bus.out_block3; dat = bus.out_data3; end
    endcase
    if (lane < 0) return dat;
    return blk[lane*W +: W];
  endfunction

  function automatic logic [W-1:0] port_ptr(input int port);
    case (port)
      1: return bus.ptr_out1;
      2: return bus.ptr_out2;
      default: return bus.ptr_out3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) model[i] = W'(i);
  endtask

  task automatic model_write();
    int base;
    base = int'(bus.ptr_in % D);
    for (int k = 0; k < B; k++) model[(base + k) % D] = bus.in_block[k*W +: W];
  endtask

  task automatic push_expect();
    sb_t e;
    int  a;
    for (int p = 1; p <= 3; p++) begin
      a = int'(port_ptr(p) % D);
      e.port = p; e.lane = -1; e.exp = model[a];
      sb_q.push_back(e);
      for (int k = 0; k < B; k++) begin
        e.lane = k; e.exp = model[(a + k) % D];
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag);
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("%s p%0d l%0d", tag, e.port, e.lane), dut_val(e.port, e.lane), e.exp);
    end
  endtask

  task automatic set_ptrs(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    bus.ptr_out1 = a;
    bus.ptr_out2 = b;
    bus.ptr_out3 = c;
    push_expect();
    drain("rd");
  endtask

  task automatic write_edge();
    @(posedge clk);
    if (rst_n && bus.write_enable) model_write();
    push_expect();
    drain("post");
  endtask

  initial begin
    bus.ptr_in = '0;
    bus.in_block = '0;
    bus.write_enable = 1'b0;
    bus.ptr_out1 = 32'd1;
    bus.ptr_out2 = 32'd2;
    bus.ptr_out3 = 32'd3;
    model_reset();

    // Reset pattern
    #12;
    check_val("rst d1", bus.out_data1, 32'd1);
    check_val("rst d2", bus.out_data2, 32'd2);
    check_val("rst d3", bus.out_data3, 32'd3);
    check_val("rst b1l3", bus.out_block1[3*W +: W], 32'd4);
    @(negedge clk);
    rst_n = 1'b1;
    set_ptrs(32'd1, 32'd2, 32'd3);
    set_ptrs(32'd60, 32'd63, 32'hFFFF_FFC5);

    // Block write at 3 with zeros
    @(negedge clk);
    set_ptrs(32'd1, 32'd2, 32'd3);
    bus.ptr_in = 32'd3;
    bus.in_block = '0;
    bus.write_enable = 1'b1;
    #1;
    check_val("pre d3", bus.out_data3, 32'd3);
    write_edge();
    check_val("wr d3", bus.out_data3, 32'd0);
    check_val("wr b1l2", bus.out_block1[2*W +: W], 32'd0);
    check_val("wr b1l1", bus.out_block1[1*W +: W], 32'd2);
    @(negedge clk);
    set_ptrs(32'd3, 32'd5, 32'd6);

    // Write disabled
    bus.write_enable = 1'b0;
    bus.in_block = {B{32'hFFFF_FFFF}};
    repeat (3) write_edge();
    check_val("dis d1", bus.out_data1, 32'd0);
    @(negedge clk);
    set_ptrs(32'd0, 32'd4, 32'd7);

    // Wrap-around write
    bus.ptr_in = 32'd62;
    bus.in_block = {32'hD, 32'hC, 32'hB, 32'hA};
    bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    model_write();
    set_ptrs(32'd64, 32'd63, 32'd62);
    check_val("wrap d1", bus.out_data1, 32'hC);
    check_val("wrap b2l3", bus.out_block2[3*W +: W], 32'd2);
    check_val("wrap b3l3", bus.out_block3[3*W +: W], 32'hD);

    // Aliased ports and write address
    @(negedge clk);
    set_ptrs(32'd10, 32'd10, 32'd10);
    bus.ptr_in = 32'd10;
    bus.in_block = {96'h0, 32'h1234};
    bus.write_enable = 1'b1;
    #1;
    check_val("alias pre", bus.out_data2, 32'd10);
    write_edge();
    check_val("alias d1", bus.out_data1, 32'h1234);
    check_val("alias d3", bus.out_data3, 32'h1234);

    // Async reset between edges with write pending
    @(negedge clk);
    set_ptrs(32'd0, 32'd62, 32'd13);
    bus.ptr_in = 32'd0;
    bus.in_block = {B{32'h5555_AAAA}};
    bus.write_enable = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("arst d1", bus.out_data1, 32'd0);
    check_val("arst d2", bus.out_data2, 32'd62);
    write_edge();
    check_val("arst hold", bus.out_data1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.write_enable = 1'b0;
    set_ptrs(32'd0, 32'd62, 32'd13);

    // Random block writes and reads against the reference array
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      bus.ptr_in = $urandom;
      for (int k = 0; k < B; k++) bus.in_block[k*W +: W] = $urandom;
      bus.write_enable = ($urandom_range(0, 3) != 0);
      set_ptrs($urandom, $urandom, bus.ptr_in + 32'd1);
      write_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
